rf_walk_bist: RTL and testbench
===============================

RF_WALK_BIST -- requirements
Module: rf_walk_bist

Interface
REQ-001 Parameter DEPTH, default 64: number of register-file entries under test.
REQ-002 Parameter WIDTH, default 64: register data width in bits.
REQ-003 Parameter ADDR_W, default 6: address width, equal to log2(DEPTH).
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1: synchronous reset, active-low.
REQ-006 Port start, input, 1: begin a test run; sampled only in IDLE.
REQ-007 Port busy, output, 1: a run is in progress.
REQ-008 Port done, output, 1: the run has finished; held until the next accepted start or reset.
REQ-009 Port pass, output, 1: valid while done=1; 1 means no mismatch was found.
REQ-010 Port write_en, output, 1: register-file write enable.
REQ-011 Port waddr, output, ADDR_W: register-file write address.
REQ-012 Port wdata, output, WIDTH: register-file write data.
REQ-013 Port read_en, output, 2: bit0 enables read port 0, bit1 enables read port 1.
REQ-014 Port raddr_0 and raddr_1, output, ADDR_W each: register-file read addresses.
REQ-015 Port rdata_0 and rdata_1, input, WIDTH each: register-file read data; combinational, valid in the same cycle as raddr/read_en.
REQ-016 Port fail_port, output, 2: failing port(s) at the first mismatch; bit0 is port 0, bit1 is port 1.
REQ-017 Port fail_addr, output, ADDR_W: register address of the first mismatch.
REQ-018 Port fail_expected and fail_actual, output, WIDTH each: expected pattern and returned data at the first mismatch; fail_actual holds rdata_0 unless only port 1 failed.

Function
REQ-019 The FSM SHALL have states IDLE, WRITE, RD0, RD1, RD01 and DONE.
REQ-020 Transitions: IDLE→WRITE on start; WRITE→RD0→RD1→RD01 one state per cycle; RD01→WRITE for the next step; after the last step RD01→DONE; DONE→WRITE on start.
REQ-021 Each register SHALL receive 2*WIDTH steps. Steps 0..WIDTH-1 are walking ones: pattern = {pattern[WIDTH-2:0],1}. Steps WIDTH..2*WIDTH-1 are walking zeros: pattern = {pattern[WIDTH-2:0],0}.
REQ-022 The pattern SHALL be 0 at the start of every register, so the first wdata is 1 and the pattern returns to 0 after the last step.
REQ-023 Registers SHALL be tested in order 0..DEPTH-1; the address counter wraps to 0 only at the end of the run.
REQ-024 In WRITE: write_en=1, waddr=current address, wdata=the new pattern, read_en=00.
REQ-025 In RD0: read_en=01, raddr_0=current address, write_en=0.
REQ-026 In RD1: read_en=10, raddr_1=current address, write_en=0.
REQ-027 In RD01: read_en=11, with both read addresses set to the current address.
REQ-028 Outside the RD states read_en=00. Outside WRITE write_en=0. waddr, raddr_0, raddr_1 and wdata hold their last values.
REQ-029 Compare: in each RD state, every enabled port's rdata SHALL be compared against the pattern at the clock edge.
REQ-030 On the first mismatch, the block SHALL capture fail_port, fail_addr, fail_expected and fail_actual, go to DONE on the next cycle with pass=0, and abort the remaining steps.
REQ-031 busy SHALL be 1 in every state except IDLE and DONE.
REQ-032 A full passing run SHALL take exactly DEPTH*2*WIDTH*4 busy cycles (32768 at default parameters).
REQ-033 done SHALL rise in the cycle after the final RD01.
REQ-034 start SHALL be ignored while busy=1.
REQ-035 An accepted start from DONE SHALL clear done, pass and all fail_* outputs.

Reset
REQ-036 While reset_n=0 at a rising edge, the FSM SHALL enter IDLE, and every output and internal counter/pattern SHALL be 0, including pass and done.
REQ-037 Reset mid-run SHALL abort immediately with no further writes issued; a new start is required after reset.

Verification
REQ-038 Reset: hold reset_n=0 for 2 cycles -> all outputs 0, FSM in IDLE.
REQ-039 Ideal RF model, DEPTH=4, WIDTH=8, start pulse -> the first 4 busy cycles are (write_en=1, waddr=0, wdata=0x01), (read_en=01, raddr_0=0), (read_en=10, raddr_1=0), (read_en=11) -> busy lasts exactly 256 cycles -> done=1, pass=1.
REQ-040 Same parameters, register 2 bit 3 stuck at 0 -> done with pass=0, fail_addr=2, fail_expected=0x0F, fail_actual=0x07, fail_port=01.
REQ-041 Model whose port 1 inverts bit 0 on register 1 only -> fail_port=10, fail_addr=1, fail_expected=0x01, fail_actual=0x00.
REQ-042 Assert reset_n=0 at busy cycle 100, then release -> IDLE with all outputs 0. A start pulse during busy in a separate run is ignored, and that run still takes 256 cycles.
REQ-043 Default parameters with the ideal model -> 32768 busy cycles, pass=1. A second start from DONE clears done and reruns.

Source files
------------

// File: rtl/rf_walk_bist_if.sv
// ---------------------------------------------------------------------------
// rf_walk_bist_if
//   Bundles the register-file side of the walking-pattern BIST: one write
//   port and two combinational read ports.
//
//   master : BIST engine (drives write/read controls, receives read data)
//   slave  : register file under test (receives controls, returns data)
//
//   write_en           register-file write enable
//   waddr / wdata      write address / write data
//   read_en[1:0]       bit0 enables read port 0, bit1 enables read port 1
//   raddr_0 / raddr_1  read addresses
//   rdata_0 / rdata_1  read data, valid in the same cycle as the address
// ---------------------------------------------------------------------------
interface rf_walk_bist_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 6
);

  logic              write_en;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [1:0]        read_en;
  logic [ADDR_W-1:0] raddr_0;
  logic [ADDR_W-1:0] raddr_1;
  logic [WIDTH-1:0]  rdata_0;
  logic [WIDTH-1:0]  rdata_1;

  modport master (
    output write_en, waddr, wdata, read_en, raddr_0, raddr_1,
    input  rdata_0, rdata_1
  );

  modport slave (
    input  write_en, waddr, wdata, read_en, raddr_0, raddr_1,
    output rdata_0, rdata_1
  );

endinterface

// File: rtl/rf_walk_bist.sv
// ---------------------------------------------------------------------------
// rf_walk_bist
//   Walking-ones / walking-zeros self test for a 1W/2R register file.
//   Every register gets 2*WIDTH steps. Each step writes the next pattern and
//   then reads it back on port 0, on port 1, and on both ports together.
//   The first mismatch is captured and the run aborts.
//
//   clk            single clock, rising edge
//   reset_n        synchronous reset, active low
//   start          begin a run (only looked at in IDLE or DONE)
//   busy           a run is in progress
//   done           run finished; held until the next accepted start/reset
//   pass           valid with done; 1 = no mismatch found
//   fail_port      port(s) that mismatched first (bit0 port 0, bit1 port 1)
//   fail_addr      register address of the first mismatch
//   fail_expected  pattern that was expected at the first mismatch
//   fail_actual    data returned (port 0 data unless only port 1 failed)
//   rf             register-file bus (master side)
// ---------------------------------------------------------------------------
module rf_walk_bist #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_port,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [WIDTH-1:0]  fail_expected,
  output logic [WIDTH-1:0]  fail_actual,
  rf_walk_bist_if.master    rf
);

  // Step counter covers 2*WIDTH steps per register.
  localparam int                STEP_W     = $clog2(2 * WIDTH);
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(2 * WIDTH - 1);
  localparam logic [STEP_W-1:0] ZERO_STEP  = STEP_W'(WIDTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_RD0   = 3'd2,
    S_RD1   = 3'd3,
    S_RD01  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q;
  state_t state_d;

  // Datapath state
  logic [ADDR_W-1:0] addr_q;
  logic [STEP_W-1:0] step_q;
  logic [WIDTH-1:0]  pattern_q;      // pattern last written to addr_q
  logic [ADDR_W-1:0] waddr_q;        // held bus addresses
  logic [ADDR_W-1:0] raddr_0_q;
  logic [ADDR_W-1:0] raddr_1_q;
  logic              pass_q;
  logic [1:0]        fail_port_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [WIDTH-1:0]  fail_expected_q;
  logic [WIDTH-1:0]  fail_actual_q;

  // Decoded controls
  logic              wr_en;
  logic [1:0]        rd_en;
  logic              start_ok;
  logic              last_step;
  logic              last_addr;
  logic              fill_bit;
  logic [WIDTH-1:0]  pattern_new;
  logic [WIDTH-1:0]  rdata [2];
  logic [1:0]        mismatch;

  // start is only accepted when no run is active
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_step = (step_q == LAST_STEP);
  assign last_addr = (addr_q == LAST_ADDR);

  // The first WIDTH steps shift in ones, the rest shift in zeros; starting
  // from zero this walks to all-ones and back to zero at the last step.
  assign fill_bit    = (step_q < ZERO_STEP);
  assign pattern_new = {pattern_q[WIDTH-2:0], fill_bit};

  assign rdata[0] = rf.rdata_0;
  assign rdata[1] = rf.rdata_1;

  // Per-port compare against the pattern written in this step; a port that
  // is not enabled in the current state never reports a mismatch.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cmp
      assign mismatch[gi] = rd_en[gi] && (rdata[gi] != pattern_q);
    end
  endgenerate

  // ------------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_WRITE;
      S_WRITE: state_d = S_RD0;
      S_RD0:   state_d = (mismatch != 2'b00) ? S_DONE : S_RD1;
      S_RD1:   state_d = (mismatch != 2'b00) ? S_DONE : S_RD01;
      S_RD01: begin
        if (mismatch != 2'b00) begin
          state_d = S_DONE;
        end else if (last_step && last_addr) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE:  if (start) state_d = S_WRITE;
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // FSM: output decode
  // ------------------------------------------------------------------------
  always_comb begin
    wr_en = 1'b0;
    rd_en = 2'b00;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
      end
      S_RD0: begin
        rd_en = 2'b01;
        busy  = 1'b1;
      end
      S_RD1: begin
        rd_en = 2'b10;
        busy  = 1'b1;
      end
      S_RD01: begin
        rd_en = 2'b11;
        busy  = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Bus outputs: the live value while the port is in use, otherwise the
  // last value driven. Outside WRITE pattern_q is exactly the last wdata.
  assign rf.write_en = wr_en;
  assign rf.read_en  = rd_en;
  assign rf.waddr    = wr_en    ? addr_q      : waddr_q;
  assign rf.wdata    = wr_en    ? pattern_new : pattern_q;
  assign rf.raddr_0  = rd_en[0] ? addr_q      : raddr_0_q;
  assign rf.raddr_1  = rd_en[1] ? addr_q      : raddr_1_q;

  assign pass          = pass_q;
  assign fail_port     = fail_port_q;
  assign fail_addr     = fail_addr_q;
  assign fail_expected = fail_expected_q;
  assign fail_actual   = fail_actual_q;

  // ------------------------------------------------------------------------
  // Datapath: address/step counters, pattern, held bus values, result
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q          <= '0;
      step_q          <= '0;
      pattern_q       <= '0;
      waddr_q         <= '0;
      raddr_0_q       <= '0;
      raddr_1_q       <= '0;
      pass_q          <= 1'b0;
      fail_port_q     <= '0;
      fail_addr_q     <= '0;
      fail_expected_q <= '0;
      fail_actual_q   <= '0;
    end else begin
      if (start_ok) begin
        // An aborted run can leave the counters mid-walk; restart cleanly.
        addr_q          <= '0;
        step_q          <= '0;
        pattern_q       <= '0;
        pass_q          <= 1'b0;
        fail_port_q     <= '0;
        fail_addr_q     <= '0;
        fail_expected_q <= '0;
        fail_actual_q   <= '0;
      end

      if (wr_en) begin
        pattern_q <= pattern_new;
        waddr_q   <= addr_q;
      end
      if (rd_en[0]) begin
        raddr_0_q <= addr_q;
      end
      if (rd_en[1]) begin
        raddr_1_q <= addr_q;
      end

      if (mismatch != 2'b00) begin
        // Only one capture can happen: the FSM leaves for DONE right away.
        fail_port_q     <= mismatch;
        fail_addr_q     <= addr_q;
        fail_expected_q <= pattern_q;
        fail_actual_q   <= mismatch[0] ? rdata[0] : rdata[1];
      end else if (state_q == S_RD01) begin
        if (last_step) begin
          step_q <= '0;
          if (last_addr) begin
            addr_q <= '0;
            pass_q <= 1'b1;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end else begin
          step_q <= step_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_walk_bist.sv
// ---------------------------------------------------------------------------
// tb_rf_walk_bist
//   Small instance (DEPTH=4, WIDTH=8) with a fault-injectable register-file
//   model, plus a default-parameter instance with an ideal model.
// ---------------------------------------------------------------------------
module tb_rf_walk_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // ---------------- small instance ----------------
  logic       s_rstn;
  logic       s_start;
  logic       s_busy, s_done, s_pass;
  logic [1:0] s_fail_port;
  logic [1:0] s_fail_addr;
  logic [7:0] s_fail_exp, s_fail_act;
  int         fault_mode = 0;

  rf_walk_bist_if #(.WIDTH(8), .ADDR_W(2)) s_rf ();

  rf_walk_bist #(.DEPTH(4), .WIDTH(8), .ADDR_W(2)) u_small (
    .clk           (clk),
    .reset_n       (s_rstn),
    .start         (s_start),
    .busy          (s_busy),
    .done          (s_done),
    .pass          (s_pass),
    .fail_port     (s_fail_port),
    .fail_addr     (s_fail_addr),
    .fail_expected (s_fail_exp),
    .fail_actual   (s_fail_act),
    .rf            (s_rf)
  );

  // fault 1: register 2 bit 3 stuck at 0; fault 2: port 1 inverts bit 0 of register 1
  logic [7:0] s_mem [4];
  always @(posedge clk) begin
    if (s_rf.write_en)
      s_mem[s_rf.waddr] <= (fault_mode == 1 && s_rf.waddr == 2'd2) ? (s_rf.wdata & 8'hF7) : s_rf.wdata;
  end
  assign s_rf.rdata_0 = s_mem[s_rf.raddr_0];
  assign s_rf.rdata_1 = (fault_mode == 2 && s_rf.raddr_1 == 2'd1) ? (s_mem[s_rf.raddr_1] ^ 8'h01)
                                                                 : s_mem[s_rf.raddr_1];

  // ---------------- default instance ----------------
  logic        b_rstn;
  logic        b_start;
  logic        b_busy, b_done, b_pass;
  logic [1:0]  b_fail_port;
  logic [5:0]  b_fail_addr;
  logic [63:0] b_fail_exp, b_fail_act;

  rf_walk_bist_if #(.WIDTH(64), .ADDR_W(6)) b_rf ();

  rf_walk_bist u_big (
    .clk           (clk),
    .reset_n       (b_rstn),
    .start         (b_start),
    .busy          (b_busy),
    .done          (b_done),
    .pass          (b_pass),
    .fail_port     (b_fail_port),
    .fail_addr     (b_fail_addr),
    .fail_expected (b_fail_exp),
    .fail_actual   (b_fail_act),
    .rf            (b_rf)
  );

  logic [63:0] b_mem [64];
  always @(posedge clk) begin
    if (b_rf.write_en) b_mem[b_rf.waddr] <= b_rf.wdata;
  end
  assign b_rf.rdata_0 = b_mem[b_rf.raddr_0];
  assign b_rf.rdata_1 = b_mem[b_rf.raddr_1];

  // ---------------- scoreboards ----------------
  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] ren;
    logic [1:0] r0;
    logic [1:0] r1;
  } bus_t;

  typedef struct {
    int         cycles;   // -1: not checked
    logic       pass;
    logic [1:0] fport;
    logic [1:0] faddr;
    logic [7:0] fexp;
    logic [7:0] fact;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  int   big_q[$];

  // Expected bus activity of a full ideal run, derived from the walk rules.
  task automatic push_ideal_bus();
    bus_t       e;
    logic [1:0] p0 = 2'd0;
    logic [1:0] p1 = 2'd0;
    logic [7:0] p;
    for (int a = 0; a < 4; a++) begin
      p = 8'h00;
      for (int s = 0; s < 16; s++) begin
        p = (s < 8) ? {p[6:0], 1'b1} : {p[6:0], 1'b0};
        e.we = 1'b1; e.wa = 2'(a); e.wd = p; e.ren = 2'b00; e.r0 = p0; e.r1 = p1;
        bus_q.push_back(e);
        e.we = 1'b0; e.ren = 2'b01; p0 = 2'(a); e.r0 = p0;
        bus_q.push_back(e);
        e.ren = 2'b10; p1 = 2'(a); e.r1 = p1;
        bus_q.push_back(e);
        e.ren = 2'b11;
        bus_q.push_back(e);
      end
    end
  endtask

  function automatic res_t mk_res(int cyc, logic ps, logic [1:0] fp, logic [1:0] fa,
                                  logic [7:0] fe, logic [7:0] fc);
    res_t r;
    r.cycles = cyc; r.pass = ps; r.fport = fp; r.faddr = fa; r.fexp = fe; r.fact = fc;
    return r;
  endfunction

  // Pulse start on the small DUT and count busy cycles until done.
  // restart_at >= 1 re-asserts start during that busy cycle.
  task automatic run_small(input int restart_at, output int cycles);
    cycles  = 0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    while (!s_done && cycles < 2000) begin
      if (s_busy) cycles++;
      s_start = (cycles == restart_at);
      @(negedge clk);
    end
    s_start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    s_rstn = 1'b0; b_rstn = 1'b0; s_start = 1'b0; b_start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_busy, s_done, s_pass} !== 3'b000) $display("FAIL reset_status: got %b want 000", {s_busy, s_done, s_pass});
    else passed++;
    checks++;
    if ({s_fail_port, s_fail_addr, s_fail_exp, s_fail_act} !== 20'h0)
      $display("FAIL reset_fail_fields: got %h want 0", {s_fail_port, s_fail_addr, s_fail_exp, s_fail_act});
    else passed++;
    checks++;
    if ({s_rf.write_en, s_rf.waddr, s_rf.wdata, s_rf.read_en, s_rf.raddr_0, s_rf.raddr_1} !== 17'h0)
      $display("FAIL reset_bus: got %h want 0", {s_rf.write_en, s_rf.waddr, s_rf.wdata, s_rf.read_en, s_rf.raddr_0, s_rf.raddr_1});
    else passed++;
    checks++;
    if ({b_busy, b_done, b_pass, b_rf.write_en, b_rf.read_en, b_rf.wdata} !== 70'h0)
      $display("FAIL reset_big: got %h want 0", {b_busy, b_done, b_pass, b_rf.write_en, b_rf.read_en, b_rf.wdata});
    else passed++;
    s_rstn = 1'b1; b_rstn = 1'b1;
    @(negedge clk);
    $display("reset: small busy=%b done=%b, big busy=%b done=%b", s_busy, s_done, b_busy, b_done);
  endtask

  task automatic test_walk_ideal();
    int   cycles = 0;
    bus_t e;
    res_t r;
    fault_mode = 0;
    push_ideal_bus();
    res_q.push_back(mk_res(256, 1'b1, 2'b00, 2'd0, 8'h00, 8'h00));
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    while (!s_done && cycles < 2000) begin
      if (s_busy) begin
        cycles++;
        if (bus_q.size() > 0) begin
          e = bus_q.pop_front();
          checks++;
          if ({s_rf.write_en, s_rf.waddr, s_rf.wdata, s_rf.read_en, s_rf.raddr_0, s_rf.raddr_1} !==
              {e.we, e.wa, e.wd, e.ren, e.r0, e.r1})
            $display("FAIL walk_bus cycle %0d: got we=%b wa=%0d wd=%h ren=%b r0=%0d r1=%0d want we=%b wa=%0d wd=%h ren=%b r0=%0d r1=%0d",
                     cycles, s_rf.write_en, s_rf.waddr, s_rf.wdata, s_rf.read_en, s_rf.raddr_0, s_rf.raddr_1,
                     e.we, e.wa, e.wd, e.ren, e.r0, e.r1);
          else passed++;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (bus_q.size() != 0) begin
      $display("FAIL walk_bus_left: %0d expected bus cycles never seen, want 0", bus_q.size());
      bus_q.delete();
    end else passed++;
    r = res_q.pop_front();
    checks++;
    if (cycles !== r.cycles) $display("FAIL walk_cycles: got %0d want %0d", cycles, r.cycles);
    else passed++;
    checks++;
    if ({s_done, s_pass, s_busy} !== {1'b1, r.pass, 1'b0})
      $display("FAIL walk_result: got done=%b pass=%b busy=%b want 1 %b 0", s_done, s_pass, s_busy, r.pass);
    else passed++;
    $display("walk_ideal: cycles=%0d done=%b pass=%b", cycles, s_done, s_pass);
  endtask

  // Shared shape for the fault scenarios: expectation queued before start.
  task automatic test_stuck_bit();
    int   cycles;
    res_t r;
    fault_mode = 1;
    res_q.push_back(mk_res(142, 1'b0, 2'b01, 2'd2, 8'h0F, 8'h07));
    run_small(-1, cycles);
    r = res_q.pop_front();
    checks++;
    if ({s_done, s_pass} !== {1'b1, r.pass}) $display("FAIL stuck_result: got done=%b pass=%b want 1 %b", s_done, s_pass, r.pass);
    else passed++;
    checks++;
    if ({s_fail_port, s_fail_addr, s_fail_exp, s_fail_act} !== {r.fport, r.faddr, r.fexp, r.fact})
      $display("FAIL stuck_capture: got port=%b addr=%0d exp=%h act=%h want port=%b addr=%0d exp=%h act=%h",
               s_fail_port, s_fail_addr, s_fail_exp, s_fail_act, r.fport, r.faddr, r.fexp, r.fact);
    else passed++;
    checks++;
    if (cycles !== r.cycles) $display("FAIL stuck_abort_cycles: got %0d want %0d", cycles, r.cycles);
    else passed++;
    $display("stuck_bit: cycles=%0d pass=%b port=%b addr=%0d exp=%h act=%h",
             cycles, s_pass, s_fail_port, s_fail_addr, s_fail_exp, s_fail_act);
  endtask

  task automatic test_restart_clears();
    int   cycles = 0;
    res_t r;
    fault_mode = 0;
    res_q.push_back(mk_res(256, 1'b1, 2'b00, 2'd0, 8'h00, 8'h00));
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    checks++;
    if ({s_busy, s_done, s_pass, s_fail_port, s_fail_addr, s_fail_exp, s_fail_act} !== {1'b1, 22'h0})
      $display("FAIL restart_clear: got busy=%b done=%b pass=%b port=%b addr=%0d exp=%h act=%h want busy=1 rest 0",
               s_busy, s_done, s_pass, s_fail_port, s_fail_addr, s_fail_exp, s_fail_act);
    else passed++;
    while (!s_done && cycles < 2000) begin
      if (s_busy) cycles++;
      @(negedge clk);
    end
    r = res_q.pop_front();
    checks++;
    if ({cycles, s_pass} !== {r.cycles, r.pass})
      $display("FAIL restart_run: got cycles=%0d pass=%b want %0d %b", cycles, s_pass, r.cycles, r.pass);
    else passed++;
    $display("restart_clears: cycles=%0d pass=%b", cycles, s_pass);
  endtask

  task automatic test_port1_invert();
    int   cycles;
    res_t r;
    fault_mode = 2;
    res_q.push_back(mk_res(67, 1'b0, 2'b10, 2'd1, 8'h01, 8'h00));
    run_small(-1, cycles);
    r = res_q.pop_front();
    checks++;
    if ({s_done, s_pass} !== {1'b1, r.pass}) $display("FAIL port1_result: got done=%b pass=%b want 1 %b", s_done, s_pass, r.pass);
    else passed++;
    checks++;
    if ({s_fail_port, s_fail_addr, s_fail_exp, s_fail_act} !== {r.fport, r.faddr, r.fexp, r.fact})
      $display("FAIL port1_capture: got port=%b addr=%0d exp=%h act=%h want port=%b addr=%0d exp=%h act=%h",
               s_fail_port, s_fail_addr, s_fail_exp, s_fail_act, r.fport, r.faddr, r.fexp, r.fact);
    else passed++;
    checks++;
    if (cycles !== r.cycles) $display("FAIL port1_abort_cycles: got %0d want %0d", cycles, r.cycles);
    else passed++;
    $display("port1_invert: cycles=%0d pass=%b port=%b addr=%0d", cycles, s_pass, s_fail_port, s_fail_addr);
    fault_mode = 0;
  endtask

  task automatic test_reset_midrun();
    int cycles = 0;
    bit activity = 1'b0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    while (cycles < 100 && !s_done) begin
      if (s_busy) cycles++;
      if (cycles < 100) @(negedge clk);
    end
    s_rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_busy, s_done, s_pass, s_fail_port, s_fail_addr, s_fail_exp, s_fail_act} !== 23'h0)
      $display("FAIL midrun_reset_status: got %h want 0", {s_busy, s_done, s_pass, s_fail_port, s_fail_addr, s_fail_exp, s_fail_act});
    else passed++;
    checks++;
    if ({s_rf.write_en, s_rf.waddr, s_rf.wdata, s_rf.read_en, s_rf.raddr_0, s_rf.raddr_1} !== 17'h0)
      $display("FAIL midrun_reset_bus: got %h want 0", {s_rf.write_en, s_rf.waddr, s_rf.wdata, s_rf.read_en, s_rf.raddr_0, s_rf.raddr_1});
    else passed++;
    s_rstn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (s_rf.write_en || s_busy || s_done) activity = 1'b1;
    end
    checks++;
    if (activity !== 1'b0) $display("FAIL midrun_stays_idle: got activity=%b want 0", activity);
    else passed++;
    $display("reset_midrun: reset at busy cycle %0d, idle afterwards=%b", cycles, !activity);
  endtask

  task automatic test_start_ignored();
    int   cycles;
    res_t r;
    res_q.push_back(mk_res(256, 1'b1, 2'b00, 2'd0, 8'h00, 8'h00));
    run_small(50, cycles);
    r = res_q.pop_front();
    checks++;
    if ({cycles, s_done, s_pass} !== {r.cycles, 1'b1, r.pass})
      $display("FAIL start_ignored: got cycles=%0d done=%b pass=%b want %0d 1 %b", cycles, s_done, s_pass, r.cycles, r.pass);
    else passed++;
    $display("start_ignored: cycles=%0d pass=%b", cycles, s_pass);
  endtask

  task automatic test_default_params();
    int cycles;
    int exp_cyc;
    for (int run = 0; run < 2; run++) begin
      cycles = 0;
      big_q.push_back(32768);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      if (run == 1) begin
        checks++;
        if ({b_busy, b_done, b_pass} !== 3'b100)
          $display("FAIL big_restart_clear: got busy=%b done=%b pass=%b want 1 0 0", b_busy, b_done, b_pass);
        else passed++;
      end
      while (!b_done && cycles < 40000) begin
        if (b_busy) cycles++;
        @(negedge clk);
      end
      exp_cyc = big_q.pop_front();
      checks++;
      if ({cycles, b_done, b_pass} !== {exp_cyc, 1'b1, 1'b1})
        $display("FAIL big_run%0d: got cycles=%0d done=%b pass=%b want %0d 1 1", run, cycles, b_done, b_pass, exp_cyc);
      else passed++;
      $display("default_params run %0d: cycles=%0d pass=%b", run, cycles, b_pass);
    end
  endtask

  initial begin
    s_rstn = 1'b0; b_rstn = 1'b0; s_start = 1'b0; b_start = 1'b0;
    test_reset();
    test_walk_ideal();
    test_stuck_bit();
    test_restart_clears();
    test_port1_invert();
    test_reset_midrun();
    test_start_ignored();
    test_default_params();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
